// File: rtl/i2s_capture_seq.sv
// rtl/i2s_capture_seq.sv - Per-frame stereo sample sequencer into the DPRAM capture ring
//
// Once per I2S frame it snapshots every left/right word of N_PAIRS I2S_RX units and
// writes them to the capture DPRAM back-to-back, one word per ck, at waddr = {chan, idx}.
// Each channel owns a ring of 2**IDX_W entries.
//
// Ports:
//   ck          in   system clock, also the DPRAM write clock
//   rst_n       in   async active-low reset
//   enable      in   capture enable, sampled only at frame detect
//   frame_posn  in   bit position within the I2S frame (from I2S_CLOCK)
//   samples     in   {right,left} per pair; pair p at [32p+31:32p]
//   we          out  DPRAM write enable (also wclke)
//   waddr       out  {chan, idx} write address
//   wdata       out  sample word being written
//   idx         out  ring slot of the most recently completed frame
//   block_done  out  1-ck pulse after the last write of ring slot 2**IDX_W-1
//   overrun     out  sticky: frame detect seen while a burst was in progress
//   clr_overrun in   clears overrun (a simultaneous set wins)
//
// Build option: CAPT_HALF_IRQ_EN also pulses block_done after slot 2**(IDX_W-1)-1,
// giving a ping-pong half-buffer notification.

module i2s_capture_seq #(
    parameter int N_PAIRS   = 2,
    parameter int CHAN_W    = 4,
    parameter int IDX_W     = 4,
    parameter int LATCH_POS = 32
) (
    input  logic                      ck,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [5:0]                frame_posn,
    input  logic [32*N_PAIRS-1:0]     samples,
    output logic                      we,
    output logic [CHAN_W+IDX_W-1:0]   waddr,
    output logic [15:0]               wdata,
    output logic [IDX_W-1:0]          idx,
    output logic                      block_done,
    output logic                      overrun,
    input  logic                      clr_overrun
);

    localparam int               NCH      = 2 * N_PAIRS;
    localparam logic [CHAN_W:0]  CHAN_END = (CHAN_W + 1)'(NCH);
    localparam logic [CHAN_W:0]  CHAN_ONE = (CHAN_W + 1)'(1);
    localparam logic [5:0]       POS      = 6'(LATCH_POS);
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_WRITE
    } state_t;

    state_t                  state;
    logic [5:0]              frame_posn_q;
    logic [32*N_PAIRS-1:0]   shadow;
    logic [CHAN_W:0]         chan;
    logic [IDX_W-1:0]        widx;
    logic                    det;
    logic                    bd_hit;

    // Rising edge into LATCH_POS: one detect per frame however long the value is held.
    assign det = (frame_posn == POS) && (frame_posn_q != POS);

`ifdef CAPT_HALF_IRQ_EN
    localparam logic [IDX_W-1:0] IDX_HALF_LAST = {1'b0, {(IDX_W - 1){1'b1}}};
    assign bd_hit = (widx == IDX_LAST) || (widx == IDX_HALF_LAST);
`else
    assign bd_hit = (widx == IDX_LAST);
`endif

    // The packed samples vector already orders its 16-bit words as
    // left0, right0, left1, right1, ... which is exactly channel order, so the
    // shadow is simply shifted down one word per write.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            frame_posn_q <= '0;
            shadow       <= '0;
            chan         <= '0;
            widx         <= '0;
            we           <= 1'b0;
            waddr        <= '0;
            wdata        <= '0;
            idx          <= '0;
            block_done   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_posn_q <= frame_posn;
            block_done   <= 1'b0;

            if (det && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    we <= 1'b0;
                    if (det && enable) begin
                        shadow <= samples;
                        state  <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    we     <= 1'b1;
                    waddr  <= {CHAN_W'(0), widx};
                    wdata  <= shadow[15:0];
                    shadow <= shadow >> 16;
                    chan   <= CHAN_ONE;
                    state  <= S_WRITE;
                end
                S_WRITE: begin
                    if (chan == CHAN_END) begin
                        we         <= 1'b0;
                        state      <= S_IDLE;
                        idx        <= widx;
                        widx       <= widx + 1'b1;
                        block_done <= bd_hit;
                    end else begin
                        we     <= 1'b1;
                        waddr  <= {chan[CHAN_W-1:0], widx};
                        wdata  <= shadow[15:0];
                        shadow <= shadow >> 16;
                        chan   <= chan + CHAN_ONE;
                    end
                end
                default: begin
                    we    <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_capture_seq.sv
// tb/tb_i2s_capture_seq.sv - Scoreboard bench for i2s_capture_seq

module tb_i2s_capture_seq;

    localparam int NP = 2;

    logic            ck = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic [5:0]      frame_posn = 6'd0;
    logic [32*NP-1:0] samples = '0;
    logic            we;
    logic [7:0]      waddr;
    logic [15:0]     wdata;
    logic [3:0]      idx;
    logic            block_done;
    logic            overrun;
    logic            clr_overrun = 1'b0;

    i2s_capture_seq #(.N_PAIRS(NP), .CHAN_W(4), .IDX_W(4), .LATCH_POS(32)) dut (
        .ck(ck), .rst_n(rst_n), .enable(enable), .frame_posn(frame_posn),
        .samples(samples), .we(we), .waddr(waddr), .wdata(wdata), .idx(idx),
        .block_done(block_done), .overrun(overrun), .clr_overrun(clr_overrun)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    wr_t        exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         bd_cnt = 0;
    logic [3:0] m_widx = 0;
    logic [3:0] m_idx = 0;
    int         m_bd = 0;

    always @(posedge ck) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every DUT write against the head of the scoreboard.
    always @(negedge ck) begin
        if (rst_n) begin
            if (block_done) bd_cnt++;
            if (we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {24'd0, waddr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("waddr", {24'd0, waddr}, {24'd0, e.addr});
                    check("wdata", {16'd0, wdata}, {16'd0, e.data});
                    check("write_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Reference model: one accepted frame writes left then right of each pair
    // into that channel's ring at the current frame slot, starting 2 ck after detect.
    task automatic model_frame(input logic [32*NP-1:0] s, input int det_cyc);
        for (int p = 0; p < NP; p++) begin
            wr_t l, r;
            l.addr = {4'(2 * p), m_widx};
            l.data = s[32*p +: 16];
            l.cyc  = det_cyc + 2 + 2 * p;
            r.addr = {4'(2 * p + 1), m_widx};
            r.data = s[32*p + 16 +: 16];
            r.cyc  = det_cyc + 3 + 2 * p;
            exp_q.push_back(l);
            exp_q.push_back(r);
        end
        m_idx = m_widx;
        if (m_widx == 4'd15) m_bd++;
`ifdef CAPT_HALF_IRQ_EN
        if (m_widx == 4'd7) m_bd++;
`endif
        m_widx = m_widx + 4'd1;
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic do_frame(input logic [32*NP-1:0] s, input bit en, input int hold);
        samples    = s;
        enable     = en;
        frame_posn = 6'd31;
        step();
        frame_posn = 6'd32;
        if (en) model_frame(s, cyc);
        repeat (hold) begin
            step();
            enable = 1'($urandom);
            samples = {$urandom, $urandom};
        end
        frame_posn = 6'd33;
        repeat (8) step();
        check("idx", {28'd0, idx}, {28'd0, m_idx});
        check("block_done_count", bd_cnt, m_bd);
    endtask

    function automatic logic [32*NP-1:0] rnd_samples();
        return {$urandom, $urandom};
    endfunction

    initial begin
        int det_cyc;

        // Reset state
        repeat (3) step();
        check("rst_we", {31'd0, we}, 0);
        check("rst_waddr", {24'd0, waddr}, 0);
        check("rst_wdata", {16'd0, wdata}, 0);
        check("rst_idx", {28'd0, idx}, 0);
        check("rst_block_done", {31'd0, block_done}, 0);
        check("rst_overrun", {31'd0, overrun}, 0);
        rst_n = 1'b1;
        repeat (2) step();

        // Directed frame: known words land on channels 0..3 of slot 0
        do_frame({16'h4444, 16'h3333, 16'h2222, 16'h1111}, 1'b1, 1);
        // Position held at LATCH_POS for 8 ck still yields exactly one burst
        do_frame(rnd_samples(), 1'b1, 8);
        // Disabled at detect: no writes, idx unchanged
        do_frame(rnd_samples(), 1'b0, 3);

        // Overrun: second detect during WRITE is dropped and flagged
        samples = rnd_samples(); enable = 1'b1; frame_posn = 6'd31;
        step();
        frame_posn = 6'd32; det_cyc = cyc; model_frame(samples, det_cyc);
        step(); frame_posn = 6'd0;
        step(); frame_posn = 6'd32; samples = rnd_samples();
        step(); frame_posn = 6'd33;
        repeat (8) step();
        check("overrun_set", {31'd0, overrun}, 1);
        check("overrun_idx", {28'd0, idx}, {28'd0, m_idx});
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        check("overrun_clr", {31'd0, overrun}, 0);

        // Set and clear in the same ck: set wins
        samples = rnd_samples(); frame_posn = 6'd31;
        step();
        frame_posn = 6'd32; det_cyc = cyc; model_frame(samples, det_cyc);
        step(); frame_posn = 6'd0;
        step(); frame_posn = 6'd32; clr_overrun = 1'b1;
        step(); frame_posn = 6'd33; clr_overrun = 1'b0;
        repeat (8) step();
        check("overrun_set_wins", {31'd0, overrun}, 1);

        // Async reset mid-burst: write enable drops immediately, ring restarts
        samples = rnd_samples(); frame_posn = 6'd31;
        step();
        frame_posn = 6'd32; det_cyc = cyc; model_frame(samples, det_cyc);
        step(); frame_posn = 6'd33;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_we", {31'd0, we}, 0);
        check("abort_idx", {28'd0, idx}, 0);
        check("abort_overrun", {31'd0, overrun}, 0);
        exp_q.delete();
        m_widx = 4'd0;
        m_idx = 4'd0;
        frame_posn = 6'd0;
        step();
        rst_n = 1'b1;
        step();

        // 18 enabled frames: full ring wrap and restart at slot 0
        for (int f = 0; f < 18; f++) do_frame(rnd_samples(), 1'b1, int'($urandom_range(1, 8)));

        // Random mix of enabled/disabled frames with random hold times
        for (int f = 0; f < 24; f++)
            do_frame(rnd_samples(), ($urandom_range(0, 3) != 0), int'($urandom_range(1, 8)));

        repeat (4) step();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
